// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, serial shift, rotate and parallel load, with
// a shift counter that pulses frame_done_o once every WIDTH shifts/rotates.
module universal_shift_reg #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  localparam int CW       = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic             serial_i,
  input  logic [WIDTH-1:0] parallel_i,
  output logic             serial_o,
  output logic [WIDTH-1:0] parallel_o,
  output logic [CW-1:0]    bit_cnt_o,
  output logic             frame_done_o
);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_SHIFT  = 2'b01,
    MODE_ROTATE = 2'b10,
    MODE_LOAD   = 2'b11
  } mode_e;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mode_e            mode;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             serial_end;
  logic             fill_bit;
  logic [WIDTH-1:0] moved;

  assign mode = mode_e'(mode_i);

  assign serial_end = LSB_FIRST ? data_q[0] : data_q[WIDTH-1];

  // Rotate feeds the outgoing serial-end bit back in; shift takes serial_i.
  assign fill_bit = (mode == MODE_ROTATE) ? serial_end : serial_i;

  always_comb begin
    if (LSB_FIRST) moved = {fill_bit, data_q[WIDTH-1:1]};
    else           moved = {data_q[WIDTH-2:0], fill_bit};
  end

  // NOTE: every signal gets a default at the top so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (clr_i) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (en_i) begin
      case (mode)
        MODE_SHIFT, MODE_ROTATE: begin
          data_d = moved;
          if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        MODE_LOAD: begin
          data_d = parallel_i;
          cnt_d  = '0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      data_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign serial_o     = serial_end;
  assign parallel_o   = data_q;
  assign bit_cnt_o    = cnt_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed-vector bench for universal_shift_reg at WIDTH=8, covering both
// serial-end orientations with one instance each on shared inputs.
module tb_universal_shift_reg;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         clr_i;
  logic         en_i;
  logic [1:0]   mode_i;
  logic         serial_i;
  logic [W-1:0] parallel_i;

  logic         lsb_ser, msb_ser;
  logic [W-1:0] lsb_par, msb_par;
  logic [2:0]   lsb_cnt, msb_cnt;
  logic         lsb_done, msb_done;

  int n_total = 0;
  int n_bad   = 0;

  universal_shift_reg #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .en_i(en_i), .mode_i(mode_i),
    .serial_i(serial_i), .parallel_i(parallel_i), .serial_o(lsb_ser),
    .parallel_o(lsb_par), .bit_cnt_o(lsb_cnt), .frame_done_o(lsb_done)
  );

  universal_shift_reg #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .en_i(en_i), .mode_i(mode_i),
    .serial_i(serial_i), .parallel_i(parallel_i), .serial_o(msb_ser),
    .parallel_o(msb_par), .bit_cnt_o(msb_cnt), .frame_done_o(msb_done)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic c, input logic e, input logic [1:0] m,
                       input logic s, input logic [W-1:0] p);
    clr_i      = c;
    en_i       = e;
    mode_i     = m;
    serial_i   = s;
    parallel_i = p;
  endtask

  // One active edge; outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [7:0] piso_exp;
    logic [7:0] sipo_in;
    logic [7:0] msb_exp;
    int         pulses;

    rst_i = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 8'h00);
    #3;
    check("por_par", lsb_par, 8'h00);
    check("por_cnt", lsb_cnt, 3'd0);
    check("por_done", lsb_done, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Async reset mid-frame: load FF, 3 shifts, reset between edges.
    drive(1'b0, 1'b1, 2'b11, 1'b0, 8'hFF); step();
    drive(1'b0, 1'b1, 2'b01, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step();
    check("pre_rst_par", lsb_par, 8'h1F);
    check("pre_rst_cnt", lsb_cnt, 3'd3);
    #1 rst_i = 1'b0;
    #1;
    check("rst_par", lsb_par, 8'h00);
    check("rst_cnt", lsb_cnt, 3'd0);
    check("rst_ser", lsb_ser, 1'b0);
    check("rst_done", lsb_done, 1'b0);
    #1 rst_i = 1'b1;
    // First edge after release operates normally; the discarded frame never pulses.
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      pulses += int'(lsb_done);
    end
    check("post_rst_cnt", lsb_cnt, 3'd5);
    check("post_rst_pulses", pulses, 0);

    // PISO, LSB first.
    piso_exp = 8'hA5;
    drive(1'b0, 1'b1, 2'b11, 1'b0, 8'hA5); step();
    check("piso_load_cnt", lsb_cnt, 3'd0);
    drive(1'b0, 1'b1, 2'b01, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("piso_ser%0d", i), lsb_ser, piso_exp[i]);
      check($sformatf("piso_done%0d", i), lsb_done, 1'b0);
      step();
    end
    check("piso_par", lsb_par, 8'h00);
    check("piso_done", lsb_done, 1'b1);
    check("piso_cnt", lsb_cnt, 3'd0);
    drive(1'b0, 1'b1, 2'b00, 1'b1, 8'h00); step();
    check("piso_done_drop", lsb_done, 1'b0);
    check("hold_par", lsb_par, 8'h00);

    // SIPO, LSB first, from a clear.
    drive(1'b1, 1'b1, 2'b01, 1'b1, 8'h00); step();
    check("clr_par", lsb_par, 8'h00);
    check("clr_cnt", lsb_cnt, 3'd0);
    sipo_in = 8'b0101_0011; // bit i is the i-th serial input
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 2'b01, sipo_in[i], 8'h00);
      step();
      pulses += int'(lsb_done);
    end
    check("sipo_par", lsb_par, 8'h53);
    check("sipo_pulses", pulses, 1);
    check("sipo_cnt", lsb_cnt, 3'd0);

    // Rotate, LSB first; serial_i is ignored.
    drive(1'b0, 1'b1, 2'b11, 1'b0, 8'h81); step();
    drive(1'b0, 1'b1, 2'b10, 1'b1, 8'h00);
    step(); check("rot1", lsb_par, 8'hC0);
    step(); check("rot2", lsb_par, 8'h60);
    step(); check("rot3", lsb_par, 8'h30);
    check("rot_cnt3", lsb_cnt, 3'd3);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rot_nodone%0d", i), lsb_done, 1'b0);
      step();
    end
    check("rot_par", lsb_par, 8'h81);
    check("rot_done", lsb_done, 1'b1);

    // Shift and rotate share one frame.
    drive(1'b1, 1'b0, 2'b00, 1'b0, 8'h00); step();
    drive(1'b0, 1'b1, 2'b01, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) step();
    check("mix_shift_par", lsb_par, 8'hF0);
    drive(1'b0, 1'b1, 2'b10, 1'b1, 8'h00);
    step(); check("mix_rot_ign", lsb_par, 8'h78);
    step(); step();
    check("mix_cnt7", lsb_cnt, 3'd7);
    check("mix_nodone", lsb_done, 1'b0);
    step();
    check("mix_par", lsb_par, 8'h0F);
    check("mix_done", lsb_done, 1'b1);

    // Back-to-back frame: keep shifting in the pulse cycle.
    drive(1'b0, 1'b1, 2'b01, 1'b0, 8'h00); step();
    check("b2b_cnt", lsb_cnt, 3'd1);
    check("b2b_done", lsb_done, 1'b0);
    for (int i = 0; i < 7; i++) step();
    check("b2b_done2", lsb_done, 1'b1);
    // Load in the pulse cycle, then abort a partial frame by another load.
    drive(1'b0, 1'b1, 2'b11, 1'b0, 8'h3C); step();
    check("b2b_load_par", lsb_par, 8'h3C);
    check("b2b_load_done", lsb_done, 1'b0);
    drive(1'b0, 1'b1, 2'b01, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step();
    drive(1'b0, 1'b1, 2'b11, 1'b0, 8'h5A); step();
    check("abort_cnt", lsb_cnt, 3'd0);
    drive(1'b0, 1'b1, 2'b01, 1'b0, 8'h00);
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      pulses += int'(lsb_done);
    end
    check("abort_pulses", pulses, 0);
    step();
    check("abort_frame_done", lsb_done, 1'b1);

    // Gating then clear with en_i low.
    drive(1'b0, 1'b1, 2'b11, 1'b0, 8'hFF); step();
    drive(1'b0, 1'b1, 2'b01, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step();
    drive(1'b0, 1'b0, 2'b01, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("gate_par%0d", i), lsb_par, 8'h1F);
      check($sformatf("gate_cnt%0d", i), lsb_cnt, 3'd3);
    end
    drive(1'b1, 1'b0, 2'b01, 1'b1, 8'h00); step();
    check("gclr_par", lsb_par, 8'h00);
    check("gclr_cnt", lsb_cnt, 3'd0);
    check("gclr_done", lsb_done, 1'b0);

    // MSB first on the second instance.
    msb_exp = 8'b0111_1000; // bit i is serial_o before edge i
    drive(1'b0, 1'b1, 2'b11, 1'b0, 8'h1E); step();
    drive(1'b0, 1'b1, 2'b01, 1'b1, 8'h00);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("msb_ser%0d", i), msb_ser, msb_exp[i]);
      step();
      pulses += int'(msb_done);
    end
    check("msb_par", msb_par, 8'hFF);
    check("msb_pulses", pulses, 1);
    check("msb_cnt", msb_cnt, 3'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
